// File: rtl/nvdla_package.sv
// Shared types and constants for the PULP peripheral-bus to NVDLA CSB sequencer.
package nvdla_package;

  localparam int          CSB_AW_DEFAULT = 16;
  localparam logic [31:0] CSB_ERR_DATA   = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD_WAIT,
    MERGE,
    WR_WAIT,
    RESP
  } csb_state_t;

endpackage

// File: rtl/nvdla_csb_byte_merge.sv
// Byte-lane merge for read-modify-write: enabled lanes take new data, the rest keep old data.
module nvdla_csb_byte_merge (
  input  logic [3:0]  i_be,
  input  logic [31:0] i_new_data,
  input  logic [31:0] i_old_data,
  output logic [31:0] o_merged
);

  always_comb begin
    // NOTE: assign a default before any conditional update so no latch is inferred.
    o_merged = i_old_data;
    for (int i = 0; i < 4; i++) begin
      if (i_be[i]) o_merged[8*i +: 8] = i_new_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/nvdla_csb_ctrl.sv
// PULP peripheral-bus slave to NVDLA CSB sequencer; one access outstanding, RMW for partial writes.
// Optional response timeout and drain logic enabled by defining NVDLA_CSB_TIMEOUT_EN.
module nvdla_csb_ctrl
  import nvdla_package::*;
#(
  parameter int ID             = 10,
  parameter int CSB_AW         = CSB_AW_DEFAULT,
  parameter int NPOSTED        = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              periph_req,
  output logic              periph_gnt,
  input  logic [31:0]       periph_add,
  input  logic              periph_wen,
  input  logic [3:0]        periph_be,
  input  logic [31:0]       periph_data,
  input  logic [ID-1:0]     periph_id,
  output logic [31:0]       periph_r_data,
  output logic              periph_r_valid,
  output logic [ID-1:0]     periph_r_id,
  output logic              csb_valid_o,
  input  logic              csb_ready_i,
  output logic [CSB_AW-1:0] csb_addr_o,
  output logic [31:0]       csb_wdat_o,
  output logic              csb_write_o,
  output logic              csb_nposted_o,
  input  logic              csb_resp_valid_i,
  input  logic [31:0]       csb_resp_data_i,
  input  logic              csb_wr_complete_i,
  output logic              err_o
);

  localparam logic W_NP = (NPOSTED != 0);

  csb_state_t        r_state;
  logic [CSB_AW-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic [ID-1:0]     r_id;
  logic              r_rmw;
  logic [31:0]       r_old;
  logic              r_csb_valid;
  logic              r_csb_write;
  logic              r_csb_nposted;
  logic [31:0]       r_csb_wdat;
  logic              r_rvalid;
  logic [31:0]       r_rdata;

  logic              w_resp_valid;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic              w_timeout_fire;
  logic [31:0]       w_merged;
  logic [31-CSB_AW:0] w_unused_add;

  assign w_unused_add = {periph_add[31:CSB_AW+2], periph_add[1:0]};

`ifdef NVDLA_CSB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_drain;
  logic             r_err;
  logic             w_in_wait;

  assign w_in_wait      = (r_state == RD_WAIT) || (r_state == WR_WAIT);
  assign w_resp_valid   = csb_resp_valid_i && !r_drain;
  assign w_timeout_fire = w_in_wait && (r_cnt == CNT_W'(TIMEOUT_CYCLES)) &&
                          !((r_state == RD_WAIT) ? w_rd_ok : w_wr_ok);
  assign err_o          = r_err;

  // Drain swallows the late reply of a timed-out access, whatever state it lands in.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_drain <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_cnt <= w_in_wait ? r_cnt + 1'b1 : '0;
      if (w_timeout_fire) begin
        r_drain <= 1'b1;
        r_err   <= 1'b1;
      end else if (csb_resp_valid_i) begin
        r_drain <= 1'b0;
      end
    end
  end
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = TIMEOUT_CYCLES;
  assign w_resp_valid     = csb_resp_valid_i;
  assign w_timeout_fire   = 1'b0;
  assign err_o            = 1'b0;
`endif

  assign w_rd_ok = w_resp_valid && !csb_wr_complete_i;
  assign w_wr_ok = w_resp_valid && csb_wr_complete_i;

  nvdla_csb_byte_merge u_merge (
    .i_be       (r_be),
    .i_new_data (r_wdata),
    .i_old_data (r_old),
    .o_merged   (w_merged)
  );

  assign periph_gnt     = (r_state == IDLE) && periph_req;
  assign periph_r_valid = r_rvalid;
  assign periph_r_data  = r_rdata;
  assign periph_r_id    = r_id;
  assign csb_valid_o    = r_csb_valid;
  assign csb_addr_o     = r_addr;
  assign csb_wdat_o     = r_csb_wdat;
  assign csb_write_o    = r_csb_write;
  assign csb_nposted_o  = r_csb_nposted;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_be          <= '0;
      r_id          <= '0;
      r_rmw         <= 1'b0;
      r_old         <= '0;
      r_csb_valid   <= 1'b0;
      r_csb_write   <= 1'b0;
      r_csb_nposted <= 1'b0;
      r_csb_wdat    <= '0;
      r_rvalid      <= 1'b0;
      r_rdata       <= '0;
    end else begin
      // NOTE: non-blocking assignments only, so every branch sees pre-edge state.
      case (r_state)
        IDLE: if (periph_req) begin
          r_wdata <= periph_data;
          r_be    <= periph_be;
          r_id    <= periph_id;
          if (periph_wen || periph_be != 4'h0) r_addr <= periph_add[CSB_AW+1:2];
          if (periph_wen || periph_be != 4'hF) begin
            r_csb_write   <= 1'b0;
            r_csb_nposted <= 1'b0;
          end
          if (periph_wen) begin
            r_rmw       <= 1'b0;
            r_csb_valid <= 1'b1;
            r_state     <= CMD;
          end else if (periph_be == 4'hF) begin
            r_rmw         <= 1'b0;
            r_csb_write   <= 1'b1;
            r_csb_nposted <= W_NP;
            r_csb_wdat    <= periph_data;
            r_csb_valid   <= 1'b1;
            r_state       <= CMD;
          end else if (periph_be == 4'h0) begin
            r_rvalid <= 1'b1;
            r_rdata  <= '0;
            r_state  <= RESP;
          end else begin
            r_rmw       <= 1'b1;
            r_csb_valid <= 1'b1;
            r_state     <= CMD;
          end
        end
        CMD: if (csb_ready_i) begin
          r_csb_valid <= 1'b0;
          if (!r_csb_write)  r_state <= RD_WAIT;
          else if (W_NP)     r_state <= WR_WAIT;
          else begin
            r_rvalid <= 1'b1;
            r_rdata  <= '0;
            r_state  <= RESP;
          end
        end
        RD_WAIT: if (w_rd_ok) begin
          if (r_rmw) begin
            r_old   <= csb_resp_data_i;
            r_state <= MERGE;
          end else begin
            r_rvalid <= 1'b1;
            r_rdata  <= csb_resp_data_i;
            r_state  <= RESP;
          end
        end else if (w_timeout_fire) begin
          r_rvalid <= 1'b1;
          r_rdata  <= CSB_ERR_DATA;
          r_state  <= RESP;
        end
        MERGE: begin
          r_rmw         <= 1'b0;
          r_csb_wdat    <= w_merged;
          r_csb_write   <= 1'b1;
          r_csb_nposted <= W_NP;
          r_csb_valid   <= 1'b1;
          r_state       <= CMD;
        end
        WR_WAIT: if (w_wr_ok) begin
          r_rvalid <= 1'b1;
          r_rdata  <= '0;
          r_state  <= RESP;
        end else if (w_timeout_fire) begin
          r_rvalid <= 1'b1;
          r_rdata  <= CSB_ERR_DATA;
          r_state  <= RESP;
        end
        RESP: begin
          r_rvalid <= 1'b0;
          r_rdata  <= '0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
